mcu_bus_regfile: RTL

Parametrised slave for the 8051-style multiplexed microcontroller bus (ABUS high address byte, DBUS low address byte then data, ALE/CSbar/Rbar/Wbar strobes). It synchronises the asynchronous MCU strobes into the `clock` domain and holds a configurable bank of control registers, such as band thresholds, operand mask and clock preset. The bank supports read-back, per-register write pulses, shadowed registers with atomic commit, and an unmapped-access counter. It sits between the MCU pins and the datapath/display logic of the chip top.

---
 rtl/mcu_bus_pkg.sv | 18 +
 rtl/bus_sync.sv | 27 ++
 rtl/mcu_bus_regfile.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/mcu_bus_pkg.sv
// Shared constants and types for the MCU bus register-file slave.
package mcu_bus_pkg;

   localparam int COMMIT_GO = 0;

   localparam logic CSBAR_IDLE = 1'b1;
   localparam logic ALE_IDLE   = 1'b0;
   localparam logic RBAR_IDLE  = 1'b1;
   localparam logic WBAR_IDLE  = 1'b1;

   typedef enum logic [1:0] {
      IDLE,
      ADDR,
      WRITE,
      READ
   } bus_phase_t;

endpackage

// File: rtl/bus_sync.sv
// Multi-flop synchroniser that resets to a caller-supplied idle value,
// so strobes come out of reset at their inactive levels.
module bus_sync #(
   parameter int            W       = 1,
   parameter int            STAGES  = 2,
   parameter logic [W-1:0]  RST_VAL = '0
) (
   input  logic          clock,
   input  logic          reset,
   input  logic [W-1:0]  d_i,
   output logic [W-1:0]  q_o
);

   logic [W-1:0] chain_q [STAGES];

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < STAGES; i++) chain_q[i] <= RST_VAL;
      end else begin
         chain_q[0] <= d_i;
         for (int i = 1; i < STAGES; i++) chain_q[i] <= chain_q[i-1];
      end
   end

   assign q_o = chain_q[STAGES-1];

endmodule

// File: rtl/mcu_bus_regfile.sv
// 8051-style multiplexed-bus slave: synchronised strobes, a register bank
// with optional shadow/commit, per-register write pulses and an error counter.
module mcu_bus_regfile
   import mcu_bus_pkg::*;
#(
   parameter int                          DATA_W      = 8,
   parameter int                          NUM_REGS    = 10,
   parameter logic [15:0]                 BASE_ADDR   = 16'h0000,
   parameter int                          SYNC_STAGES = 2,
   parameter logic [NUM_REGS-1:0]         SHADOW_MASK = '0,
   parameter logic [NUM_REGS*DATA_W-1:0]  RESET_VAL   = '0
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic [7:0]                    ABUS,
   inout  wire  [DATA_W-1:0]             DBUS,
   input  logic                          CSbar,
   input  logic                          ALE,
   input  logic                          Rbar,
   input  logic                          Wbar,
   output logic [NUM_REGS*DATA_W-1:0]    regs_o,
   output logic [NUM_REGS-1:0]           wr_pulse_o,
   output logic [7:0]                    err_cnt_o,
   output logic                          dbus_oe
);

   logic [3:0]          strb_s;
   logic [7+DATA_W:0]   bus_s;
   logic                cs_s, ale_s, rbar_s, wbar_s;
   logic [DATA_W-1:0]   dbus_s;
   logic [7:0]          abus_s;

   bus_sync #(
      .W       (4),
      .STAGES  (SYNC_STAGES),
      .RST_VAL ({CSBAR_IDLE, ALE_IDLE, RBAR_IDLE, WBAR_IDLE})
   ) u_sync_strb (
      .clock (clock),
      .reset (reset),
      .d_i   ({CSbar, ALE, Rbar, Wbar}),
      .q_o   (strb_s)
   );

   bus_sync #(
      .W       (8 + DATA_W),
      .STAGES  (SYNC_STAGES),
      .RST_VAL ('0)
   ) u_sync_bus (
      .clock (clock),
      .reset (reset),
      .d_i   ({ABUS, DBUS}),
      .q_o   (bus_s)
   );

   assign {cs_s, ale_s, rbar_s, wbar_s} = strb_s;
   assign {abus_s, dbus_s}              = bus_s;

   logic                cs_prev_q, ale_prev_q, rbar_prev_q, wbar_prev_q;
   logic [15:0]         addr_cap_q, addr_q;
   logic                addr_valid_q;
   logic [DATA_W-1:0]   wdata_q, rdata_q, rd_mux;
   logic [7:0]          err_q, err_d;
   logic                dbus_oe_q;
   logic [NUM_REGS-1:0] wr_pulse_q, hit;
   logic [DATA_W-1:0]   live_q  [NUM_REGS];
   logic [DATA_W-1:0]   stage_q [NUM_REGS];
   bus_phase_t          phase_q, phase_d;

   logic [15:0] idx;
   logic        is_reg, is_commit, wr_evt, rd_fall, rd_active, commit_go, err_inc;

   // Edges are taken on the synchronised strobes against their previous value.
   assign idx       = addr_q - BASE_ADDR;
   assign is_reg    = idx < 16'(NUM_REGS);
   assign is_commit = idx == 16'(NUM_REGS);
   assign wr_evt    = !wbar_prev_q && wbar_s && !cs_s && addr_valid_q;
   assign rd_fall   = rbar_prev_q && !rbar_s && wbar_s && !cs_s && addr_valid_q;
   assign rd_active = !cs_s && !rbar_s && wbar_s && addr_valid_q;
   assign commit_go = wr_evt && is_commit && wdata_q[COMMIT_GO];
   assign err_inc   = (wr_evt || rd_fall) && !is_reg && !is_commit;

   for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
      assign hit[gi] = wr_evt && (idx == 16'(gi));
      assign regs_o[gi*DATA_W +: DATA_W] = live_q[gi];
   end

   always_comb begin
      rd_mux = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (idx == 16'(i)) rd_mux = live_q[i];
      end
   end

   always_comb begin
      err_d = err_q;
      if (err_inc && err_q != 8'hFF) err_d = err_q + 8'd1;
   end

   // Debug-only view of where the MCU is in its bus cycle.
   always_comb begin
      phase_d = phase_q;
      case (phase_q)
         IDLE:    if (ale_s) phase_d = ADDR;
         ADDR: begin
            if (!ale_s && !wbar_s)      phase_d = WRITE;
            else if (!ale_s && !rbar_s) phase_d = READ;
         end
         WRITE:   if (wbar_s) phase_d = ADDR;
         READ:    if (rbar_s) phase_d = ADDR;
         default: phase_d = IDLE;
      endcase
      if (cs_s) phase_d = IDLE;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         cs_prev_q    <= CSBAR_IDLE;
         ale_prev_q   <= ALE_IDLE;
         rbar_prev_q  <= RBAR_IDLE;
         wbar_prev_q  <= WBAR_IDLE;
         addr_cap_q   <= '0;
         addr_q       <= '0;
         addr_valid_q <= 1'b0;
         wdata_q      <= '0;
         rdata_q      <= '0;
         err_q        <= '0;
         dbus_oe_q    <= 1'b0;
         phase_q      <= IDLE;
      end else begin
         cs_prev_q   <= cs_s;
         ale_prev_q  <= ale_s;
         rbar_prev_q <= rbar_s;
         wbar_prev_q <= wbar_s;
         if (ale_s)   addr_cap_q <= {abus_s, dbus_s[7:0]};
         if (!wbar_s) wdata_q    <= dbus_s;
         if (ale_prev_q && !ale_s && !cs_s) begin
            addr_q       <= addr_cap_q;
            addr_valid_q <= 1'b1;
         end else if (!cs_prev_q && cs_s) begin
            addr_valid_q <= 1'b0;
         end
         err_q     <= err_d;
         dbus_oe_q <= rd_active;
         rdata_q   <= (is_reg) ? rd_mux : '0;
         phase_q   <= phase_d;
      end
   end

   // Shadowed registers only reach the live copy through a commit.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wr_pulse_q <= '0;
         for (int i = 0; i < NUM_REGS; i++) begin
            live_q[i]  <= RESET_VAL[i*DATA_W +: DATA_W];
            stage_q[i] <= RESET_VAL[i*DATA_W +: DATA_W];
         end
      end else begin
         wr_pulse_q <= '0;
         for (int i = 0; i < NUM_REGS; i++) begin
            if (SHADOW_MASK[i]) begin
               if (hit[i]) stage_q[i] <= wdata_q;
               if (commit_go) begin
                  live_q[i]     <= stage_q[i];
                  wr_pulse_q[i] <= 1'b1;
               end
            end else if (hit[i]) begin
               live_q[i]     <= wdata_q;
               wr_pulse_q[i] <= 1'b1;
            end
         end
      end
   end

   assign DBUS       = dbus_oe_q ? rdata_q : {DATA_W{1'bz}};
   assign dbus_oe    = dbus_oe_q;
   assign err_cnt_o  = err_q;
   assign wr_pulse_o = wr_pulse_q;

endmodule
